mux_arb_reg: RTL and testbench

Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshakes on every input channel and on the output. It generalises the fixed 8:1 32-bit combinational selector used in the processor datapath. It adds a round-robin arbitration mode, backpressure, and a one-cycle pipeline register. It sits between multiple producer stages (e.g. writeback sources, forwarding paths) and a single consumer stage.

---
 rtl/mux_arb_reg_pkg.sv | 22 ++
 rtl/mux_arb_reg_if.sv | 27 ++
 rtl/mux_arb_reg_rr_pick.sv | 25 ++
 rtl/mux_arb_reg.sv | 92 +++++++++
 tb/tb_mux_arb_reg.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_reg_pkg.sv
// Shared definitions for the registered channel selector/arbiter.
package mux_arb_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef struct packed {
        int unsigned msb;
        int unsigned lsb;
    } slice_t;

    // Bit bounds of channel idx in an n-channel, w-bit packed bus; channel 0 is the MSB slice.
    function automatic slice_t chan_slice(input int unsigned idx,
                                          input int unsigned n,
                                          input int unsigned w);
        slice_t s;
        s.msb = (n - idx) * w - 1;
        s.lsb = (n - idx - 1) * w;
        return s;
    endfunction

endpackage

// File: rtl/mux_arb_reg_if.sv
// Producer/consumer handshake bundle for mux_arb_reg.
// The master side drives channel data and consumes OUT; the slave side is the selector.
interface mux_arb_reg_if #(
    parameter int W = 32,
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_ch;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/mux_arb_reg_rr_pick.sv
// Circular priority encoder: first set request strictly after ptr, wrapping at N.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic          grant_valid_o,
    output logic [SW-1:0] grant_idx_o
);

    // Scan from the farthest offset down so the nearest request after ptr wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = SW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel W-bit selector with fixed or round-robin grant and a single
// registered output entry. Drain and reload may happen in the same cycle.
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_i,
    input  logic [SW-1:0] sel_i,
    mux_arb_reg_if.slave  bus
);

    logic [W-1:0]  chan_data [N];
    logic          fix_valid;
    logic          rr_valid;
    logic [SW-1:0] rr_idx;
    logic          gnt_valid;
    logic [SW-1:0] gnt_idx;
    logic          load_en;

    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_ch_q;
    logic          out_valid_q;
    logic [SW-1:0] ptr_q;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        localparam slice_t SL = chan_slice(i, N, W);
        assign chan_data[i] = bus.in_data[SL.msb:SL.lsb];
    end

    // Fixed grant: SEL must name an existing, valid channel; out-of-range SEL matches nothing.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_valid[i] && (sel_i == SW'(i))) begin
                fix_valid = 1'b1;
            end
        end
    end

    rr_pick #(.N(N), .SW(SW)) u_rr_pick (
        .req_i         (bus.in_valid),
        .ptr_i         (ptr_q),
        .grant_valid_o (rr_valid),
        .grant_idx_o   (rr_idx)
    );

    // Select between fixed and round-robin grant; the register accepts when empty or draining.
    always_comb begin
        gnt_valid = (mode_i == MODE_RR) ? rr_valid : fix_valid;
        gnt_idx   = (mode_i == MODE_RR) ? rr_idx   : sel_i;
        load_en   = ~out_valid_q | bus.out_ready;
    end

    // One-hot accept; reset gates it so nothing is taken while the register is being cleared.
    always_comb begin
        bus.in_ready = '0;
        if (load_en && gnt_valid && !rst) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output entry and round-robin pointer; ptr starts at N-1 so channel 0 gets first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SW'(N - 1);
        end else if (load_en) begin
            if (gnt_valid) begin
                out_data_q  <= chan_data[gnt_idx];
                out_ch_q    <= gnt_idx;
                out_valid_q <= 1'b1;
                if (mode_i == MODE_RR) begin
                    ptr_q <= gnt_idx;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mux_arb_reg;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int SW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          mode;
    logic [SW-1:0] sel;

    mux_arb_reg_if #(.W(W), .N(N)) bus ();

    mux_arb_reg #(.W(W), .N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode),
        .sel_i  (sel),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic         m_ov;
    logic [W-1:0] m_out;
    int           m_ch;
    int           m_ptr;
    logic [W-1:0] dat [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_ov  = 1'b0;
        m_out = '0;
        m_ch  = 0;
        m_ptr = N - 1;
    endtask

    // One cycle: drive inputs, check combinational accept and current outputs, advance model.
    task automatic step(input logic m, input int s, input logic [N-1:0] v, input logic r);
        int           g;
        logic         ld;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        mode = m;
        sel  = SW'(s);
        bus.in_valid  = v;
        bus.out_ready = r;
        for (int i = 0; i < N; i++) bus.in_data[(N - 1 - i) * W +: W] = dat[i];
        #1;
        g = -1;
        if (m == 1'b0) begin
            if (s < N && v[s]) g = s;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        ld = !m_ov || r;
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("out_data",  64'(bus.out_data),  64'(m_out));
        chk("out_ch",    64'(bus.out_ch),    64'(m_ch));
        if (ld) begin
            if (g >= 0) begin
                m_out = dat[g];
                m_ch  = g;
                m_ov  = 1'b1;
                if (m) m_ptr = g;
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        @(negedge clk);
        bus.in_valid  = v;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_ch",    64'(bus.out_ch),    64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        model_reset();
        bus.in_valid = '0;
        #2 rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        sel  = '0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        model_reset();

        do_reset(8'hFF);

        // Fixed select of channel 0
        dat[0] = 32'hDEADBEEF;
        step(1'b0, 0, 8'h01, 1'b1);
        chk("fx_out",   64'(bus.out_data),  64'hDEADBEEF);
        chk("fx_ch",    64'(bus.out_ch),    64'd0);
        chk("fx_valid", 64'(bus.out_valid), 64'd1);

        // Selected channel not valid: word drains, nothing reloads
        step(1'b0, 5, 8'h1F, 1'b1);
        step(1'b0, 5, 8'h1F, 1'b1);
        chk("fx_novalid", 64'(bus.out_valid), 64'd0);

        // Backpressure with channel 4 waiting
        dat[3] = 32'h3;
        dat[4] = 32'h4;
        step(1'b0, 3, 8'h08, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 4, 8'h10, 1'b0);
            chk("bp_hold_data", 64'(bus.out_data), 64'h3);
            chk("bp_hold_ch",   64'(bus.out_ch),   64'd3);
        end
        step(1'b0, 4, 8'h10, 1'b1);
        chk("bp_reload_ch",    64'(bus.out_ch),    64'd4);
        chk("bp_reload_valid", 64'(bus.out_valid), 64'd1);

        // Round-robin fairness from reset
        do_reset(8'h00);
        for (int i = 0; i < N; i++) dat[i] = W'(i);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 0, 8'hFF, 1'b1);
            chk("rr_seq_ch",   64'(bus.out_ch),   64'(k % N));
            chk("rr_seq_data", 64'(bus.out_data), 64'(k % N));
        end

        // Round-robin skip over invalid channels
        step(1'b1, 0, 8'h04, 1'b1);
        chk("rr_skip_2", 64'(bus.out_ch), 64'd2);
        step(1'b1, 0, 8'h84, 1'b1);
        chk("rr_skip_7", 64'(bus.out_ch), 64'd7);
        step(1'b1, 0, 8'h84, 1'b1);
        chk("rr_skip_2b", 64'(bus.out_ch), 64'd2);

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) dat[i] = W'($urandom);
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                 N'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Reset while a word is held and all channels are valid
        step(1'b1, 0, 8'hFF, 1'b0);
        chk("mid_held", 64'(bus.out_valid), 64'd1);
        do_reset(8'hFF);
        step(1'b1, 0, 8'hFF, 1'b1);
        chk("post_rst_ch",    64'(bus.out_ch),    64'd0);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
